// File: rtl/tc_filerom_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tc_filerom_arb_pkg
// Brief    : Shared types and constants for the TC_FileRom fetch arbiter
// Revision : 1.0 - initial release
// ============================================================================
package tc_filerom_arb_pkg;

  localparam int MAX_BYTES = 8;
  localparam int LEN_W     = 3;

  // Grant identifiers; stored in the grant register and the RR pointer
  localparam logic GNT_A = 1'b0;
  localparam logic GNT_B = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage : tc_filerom_arb_pkg
`default_nettype wire

// File: rtl/tc_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module   : tc_rr_arb2
// Brief    : Two-way round-robin arbiter. grant_o is combinational from
//            req_i; the priority pointer moves only when advance_i commits.
// Revision : 1.0 - initial release
// ============================================================================
module tc_rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_i,      // [0] = A, [1] = B
  input  logic       advance_i,  // grant is being taken this cycle
  output logic [1:0] grant_o
);
  import tc_filerom_arb_pkg::*;

  // Requester favoured on a tie; always the one not granted last
  logic prio_q;
  logic prio_d;

  // Tie goes to the favoured side; a lone request is granted directly
  always_comb begin
    grant_o = 2'b00;
    if (req_i == 2'b11) begin
      grant_o = (prio_q == GNT_B) ? 2'b10 : 2'b01;
    end else begin
      grant_o = req_i;
    end
  end

  // After a committed grant, favour the other requester
  always_comb begin
    prio_d = prio_q;
    if (advance_i && (|req_i)) begin
      prio_d = grant_o[0] ? GNT_B : GNT_A;
    end
  end

  // Pointer register; reset favours A
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_q <= GNT_A;
    end else begin
      prio_q <= prio_d;
    end
  end

endmodule : tc_rr_arb2
`default_nettype wire

// File: rtl/tc_filerom_fetch_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tc_filerom_fetch_arbiter
// Brief    : Shares one byte-wide ROM port between an instruction-fetch (A)
//            and a data-load (B) requester. Each grant runs a little-endian
//            multi-byte burst pipelined against the ROM read latency and
//            returns the assembled word with a one-cycle done pulse.
// Revision : 1.0 - initial release
// ============================================================================
module tc_filerom_fetch_arbiter #(
  parameter int ADDR_W      = 16,
  parameter int MAX_BYTES   = tc_filerom_arb_pkg::MAX_BYTES,
  parameter int LEN_W       = tc_filerom_arb_pkg::LEN_W,
  parameter int ROM_LATENCY = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   a_req_i,
  input  logic [ADDR_W-1:0]      a_addr_i,
  input  logic [LEN_W-1:0]       a_len_i,
  output logic                   a_done_o,
  input  logic                   b_req_i,
  input  logic [ADDR_W-1:0]      b_addr_i,
  input  logic [LEN_W-1:0]       b_len_i,
  output logic                   b_done_o,
  output logic [8*MAX_BYTES-1:0] rsp_data_o,
  output logic                   rom_en_o,
  output logic [ADDR_W-1:0]      rom_address_o,
  input  logic [7:0]             rom_out_i
);
  import tc_filerom_arb_pkg::*;

  state_e                 state_q, state_d;
  logic                   gnt_b_q, gnt_b_d;   // holds GNT_A / GNT_B
  logic [ADDR_W-1:0]      addr_q, addr_d;     // next address to issue
  logic [LEN_W-1:0]       len_q, len_d;
  logic [LEN_W-1:0]       cnt_q, cnt_d;       // index of byte being issued
  logic [8*MAX_BYTES-1:0] rsp_q, rsp_d;

  // Capture pipe: stage i carries the byte index issued i+1 cycles ago
  logic [ROM_LATENCY-1:0]            pvld_q;
  logic [ROM_LATENCY-1:0][LEN_W-1:0] pidx_q;

  logic [1:0] arb_req;
  logic [1:0] arb_gnt;
  logic       arb_advance;
  logic       cap_last;

  assign arb_req = {b_req_i, a_req_i};

  tc_rr_arb2 u_rr_arb2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_i     (arb_req),
    .advance_i (arb_advance),
    .grant_o   (arb_gnt)
  );

  // The final byte of the burst is on rom_out this cycle
  assign cap_last = pvld_q[ROM_LATENCY-1] && (pidx_q[ROM_LATENCY-1] == len_q);

  // Next-state, burst bookkeeping and byte assembly
  always_comb begin
    state_d     = state_q;
    gnt_b_d     = gnt_b_q;
    addr_d      = addr_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    rsp_d       = rsp_q;
    arb_advance = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (|arb_req) begin
          arb_advance = 1'b1;
          gnt_b_d     = arb_gnt[1] ? GNT_B : GNT_A;
          addr_d      = arb_gnt[1] ? b_addr_i : a_addr_i;
          len_d       = arb_gnt[1] ? b_len_i : a_len_i;
          cnt_d       = '0;
          rsp_d       = '0;  // bytes above len must read as zero
          state_d     = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        addr_d = addr_q + 1'b1;  // natural wrap at 2^ADDR_W
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == len_q) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (cap_last) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    // Bytes land in order of their index, overlapping ISSUE when latency is short
    if (pvld_q[ROM_LATENCY-1]) begin
      rsp_d[{pidx_q[ROM_LATENCY-1], 3'b000} +: 8] = rom_out_i;
    end
  end

  // FSM and datapath registers; reset aborts any burst in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      gnt_b_q <= GNT_A;
      addr_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      rsp_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_b_q <= gnt_b_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      rsp_q   <= rsp_d;
    end
  end

  // Valid/index shift pipe matching the ROM read latency
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pvld_q <= '0;
      pidx_q <= '0;
    end else begin
      pvld_q[0] <= (state_q == ST_ISSUE);
      pidx_q[0] <= cnt_q;
      for (int i = 1; i < ROM_LATENCY; i++) begin
        pvld_q[i] <= pvld_q[i-1];
        pidx_q[i] <= pidx_q[i-1];
      end
    end
  end

  assign rom_en_o      = (state_q == ST_ISSUE);
  assign rom_address_o = rom_en_o ? addr_q : '0;
  assign a_done_o      = (state_q == ST_DONE) && (gnt_b_q == GNT_A);
  assign b_done_o      = (state_q == ST_DONE) && (gnt_b_q == GNT_B);
  assign rsp_data_o    = rsp_q;

endmodule : tc_filerom_fetch_arbiter
`default_nettype wire

// File: tb/tb_tc_filerom_fetch_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_tc_filerom_fetch_arbiter
// Brief    : Directed bench for the ROM fetch arbiter. Two DUTs, ROM latency
//            1 and 3, each with a ROM model returning address[7:0].
// Revision : 1.0 - initial release
// ============================================================================
module tb_tc_filerom_fetch_arbiter;

  localparam int NI = 2;

  logic        clk;
  logic        rst_n;
  logic        a_req   [NI];
  logic [15:0] a_addr  [NI];
  logic [2:0]  a_len   [NI];
  logic        a_done  [NI];
  logic        b_req   [NI];
  logic [15:0] b_addr  [NI];
  logic [2:0]  b_len   [NI];
  logic        b_done  [NI];
  logic [63:0] rsp     [NI];
  logic        rom_en  [NI];
  logic [15:0] rom_addr[NI];
  logic [7:0]  rom_out [NI];

  int checks;
  int errors;
  int cur_inst;

  typedef struct {
    logic        sel_b;
    logic [15:0] addr;
    logic [2:0]  len;
    logic [63:0] data;
  } vec_t;

  vec_t tbl[5];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int lat_of(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int LAT = (g == 0) ? 1 : 3;
    logic [7:0] rp [LAT];

    // ROM model: data equals the low address byte, LAT cycles later
    always_ff @(posedge clk) begin
      rp[0] <= rom_addr[g][7:0];
      for (int j = 1; j < LAT; j++) rp[j] <= rp[j-1];
    end
    assign rom_out[g] = rp[LAT-1];

    tc_filerom_fetch_arbiter #(
      .ADDR_W(16), .MAX_BYTES(8), .LEN_W(3), .ROM_LATENCY(LAT)
    ) u_dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .a_req_i       (a_req[g]),
      .a_addr_i      (a_addr[g]),
      .a_len_i       (a_len[g]),
      .a_done_o      (a_done[g]),
      .b_req_i       (b_req[g]),
      .b_addr_i      (b_addr[g]),
      .b_len_i       (b_len[g]),
      .b_done_o      (b_done[g]),
      .rsp_data_o    (rsp[g]),
      .rom_en_o      (rom_en[g]),
      .rom_address_o (rom_addr[g]),
      .rom_out_i     (rom_out[g])
    );
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s (lat=%0d) at %0t: got %h expected %h", nm, lat_of(cur_inst), $time, act, want);
    end
  endtask

  // Called at a negedge in an IDLE cycle T; grant happens at the end of T
  task automatic burst(input int i, input logic sel_b, input logic [15:0] addr,
                       input logic [2:0] len, input logic [63:0] want);
    int          lat;
    int          dk;
    int          bad;
    logic        ee;
    logic [15:0] ea;
    lat = lat_of(i);
    dk  = int'(len) + 2 + lat;
    bad = 0;
    cur_inst = i;
    if (sel_b) begin
      b_req[i] = 1'b1; b_addr[i] = addr; b_len[i] = len;
    end else begin
      a_req[i] = 1'b1; a_addr[i] = addr; a_len[i] = len;
    end
    for (int k = 1; k <= dk + 1; k++) begin
      @(negedge clk);
      ee = (k <= int'(len) + 1);
      ea = ee ? (addr + 16'(k - 1)) : 16'h0000;
      if (rom_en[i] !== ee || rom_addr[i] !== ea) begin
        bad++;
        $display("  cycle T+%0d: rom_en=%b addr=%h, wanted %b %h", k, rom_en[i], rom_addr[i], ee, ea);
      end
      if (k == dk) begin
        chk("done_side", {62'd0, a_done[i], b_done[i]}, sel_b ? 64'd1 : 64'd2);
        chk("burst_data", rsp[i], want);
        a_req[i] = 1'b0;
        b_req[i] = 1'b0;
      end else if (k == dk + 1) begin
        chk("rsp_hold", rsp[i], want);
        chk("no_done_after", {62'd0, a_done[i], b_done[i]}, 64'd0);
      end else if (a_done[i] || b_done[i]) begin
        bad++;
      end
    end
    chk("issue_timing_bad_cycles", 64'(bad), 64'd0);
  endtask

  task automatic contention(input int i);
    int lat;
    int n;
    lat = lat_of(i);
    n = 0;
    cur_inst = i;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    a_req[i] = 1'b1; a_addr[i] = 16'h0020; a_len[i] = 3'd0;
    b_req[i] = 1'b1; b_addr[i] = 16'h0030; b_len[i] = 3'd0;
    for (int k = 1; k <= 4 * (3 + lat) + 8 && n < 4; k++) begin
      @(negedge clk);
      if (a_done[i] || b_done[i]) begin
        chk("cont_both_done", {63'd0, a_done[i] & b_done[i]}, 64'd0);
        chk("cont_side", {62'd0, a_done[i], b_done[i]}, (n % 2 == 0) ? 64'd2 : 64'd1);
        chk("cont_data", rsp[i], (n % 2 == 0) ? 64'h20 : 64'h30);
        chk("cont_cycle", 64'(k), 64'(2 + lat + n * (3 + lat)));
        n++;
      end
    end
    a_req[i] = 1'b0;
    b_req[i] = 1'b0;
    chk("cont_done_count", 64'(n), 64'd4);
  endtask

  task automatic midreset(input int i);
    int nd;
    nd = 0;
    cur_inst = i;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    a_req[i] = 1'b1; a_addr[i] = 16'h0100; a_len[i] = 3'd7;
    repeat (3) @(negedge clk);
    chk("midrst_issuing", {63'd0, rom_en[i]}, 64'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_en_drop", {47'd0, rom_en[i], rom_addr[i]}, 64'd0);
    repeat (3) begin
      @(negedge clk);
      if (a_done[i] || b_done[i]) nd++;
    end
    chk("midrst_no_done", 64'(nd), 64'd0);
    chk("midrst_rsp_clear", rsp[i], 64'd0);
    rst_n = 1'b1;
    burst(i, 1'b0, 16'h0100, 3'd7, 64'h0706_0504_0302_0100);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    errors = 0;
    cur_inst = 0;
    rst_n = 1'b0;
    for (int i = 0; i < NI; i++) begin
      a_req[i] = 1'b0; a_addr[i] = '0; a_len[i] = '0;
      b_req[i] = 1'b0; b_addr[i] = '0; b_len[i] = '0;
    end

    tbl[0] = '{1'b0, 16'h0010, 3'd3, 64'h0000_0000_1312_1110};
    tbl[1] = '{1'b1, 16'hFFFE, 3'd3, 64'h0000_0000_0100_FFFE};
    tbl[2] = '{1'b0, 16'h0100, 3'd7, 64'h0706_0504_0302_0100};
    tbl[3] = '{1'b1, 16'h0042, 3'd0, 64'h0000_0000_0000_0042};
    tbl[4] = '{1'b0, 16'h12FF, 3'd1, 64'h0000_0000_0000_00FF};

    repeat (2) @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      cur_inst = i;
      chk("reset_rsp", rsp[i], 64'd0);
      chk("reset_ctrl", {45'd0, rom_en[i], rom_addr[i], a_done[i], b_done[i]}, 64'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < NI; i++) begin
      for (int v = 0; v < 5; v++) begin
        burst(i, tbl[v].sel_b, tbl[v].addr, tbl[v].len, tbl[v].data);
      end
      contention(i);
      midreset(i);
    end

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_tc_filerom_fetch_arbiter
`default_nettype wire
